// File: rtl/scroll_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : scroll_pkg                                                 |
// | Brief   : Shared types and constants for the scroll sequencer        |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
package scroll_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SCROLL = 2'd2,
        CLEAR  = 2'd3
    } state_t;

    localparam logic [3:0] BLANK_DIGIT    = 4'hF;
    localparam int         NUM_FRAMES     = 7;
    localparam int         DIGITS_PER_MSG = 3;

endpackage
`default_nettype wire

// File: rtl/scroll_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : scroll_fifo                                                |
// | Brief   : Synchronous digit FIFO with flush, full/empty and count    |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
module scroll_fifo #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        push,
    input  logic                        pop,
    input  logic [3:0]                  wdata,
    output logic [3:0]                  rdata,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [3:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   count_q;
    logic          w_push;
    logic          w_pop;

    assign full   = (count_q == (AW+1)'(FIFO_DEPTH));
    assign empty  = (count_q == '0);
    assign count  = count_q;
    assign rdata  = mem_q[rptr_q];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push && !rst && !flush) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (w_push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (w_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/scroll_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : scroll_ctrl                                                |
// | Brief   : Buffers digits, loads 3-digit messages and paces a 7-frame |
// |           scroll pass. SCROLL_CTRL_LOOP_EN replays the last message. |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
module scroll_ctrl
    import scroll_pkg::*;
#(
    parameter int TICK_DIV   = 25_000_000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] in_dec,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       abort,
    output logic [3:0] dec,
    output logic       rd,
    output logic       clean,
    output logic       frame_tick,
    output logic [2:0] frame_idx,
    output logic       busy,
    output logic       done
);

    localparam int             TW         = $clog2(TICK_DIV);
    localparam int             CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [TW-1:0]  TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [2:0]     FRAME_LAST = 3'(NUM_FRAMES - 1);
    localparam logic [CW-1:0]  MSG_CNT    = CW'(DIGITS_PER_MSG);
    localparam logic [1:0]     LOAD_GAP   = 2'(DIGITS_PER_MSG);

    state_t        state_q, state_d;
    logic [1:0]    load_k_q, load_k_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    frame_q, frame_d;
    logic [3:0]    dec_q, dec_d;
    logic          aborted_q, aborted_d;

    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [3:0]    w_rdata;
    logic          w_push;
    logic          w_pop;
    logic          w_have_msg;

    // Space is judged on the pre-cycle count; an abort drops the push.
    assign in_ready   = !w_full;
    assign w_push     = in_valid && in_ready && !abort;
    assign w_have_msg = (w_count >= MSG_CNT);

    scroll_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (abort),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (in_dec),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    always_comb begin
        state_d    = state_q;
        load_k_d   = load_k_q;
        tick_d     = tick_q;
        frame_d    = frame_q;
        dec_d      = dec_q;
        aborted_d  = 1'b0;
        rd         = 1'b0;
        clean      = 1'b0;
        done       = 1'b0;
        frame_tick = 1'b0;
        w_pop      = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_have_msg) begin
                    state_d  = LOAD;
                    load_k_d = 2'd0;
                end
            end
            LOAD: begin
                if (load_k_q != LOAD_GAP) begin
                    rd       = 1'b1;
                    w_pop    = !w_empty;
                    dec_d    = w_rdata;
                    load_k_d = load_k_q + 2'd1;
                end else begin
                    state_d = SCROLL;
                    tick_d  = '0;
                    frame_d = 3'd0;
                end
            end
            SCROLL: begin
                if (tick_q == TICK_LAST) begin
                    frame_tick = 1'b1;
                    tick_d     = '0;
                    if (frame_q == FRAME_LAST) begin
                        frame_d = 3'd0;
                        state_d = CLEAR;
                    end else begin
                        frame_d = frame_q + 3'd1;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            CLEAR: begin
                clean    = 1'b1;
                done     = !aborted_q;
                load_k_d = 2'd0;
                if (w_have_msg) begin
                    state_d = LOAD;
                end else begin
`ifdef SCROLL_CTRL_LOOP_EN
                    // Replay: the scroller still holds the last message.
                    if (!aborted_q) begin
                        clean   = 1'b0;
                        state_d = SCROLL;
                        tick_d  = '0;
                        frame_d = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d   = CLEAR;
            aborted_d = 1'b1;
            rd        = 1'b0;
            w_pop     = 1'b0;
            dec_d     = dec_q;
            load_k_d  = 2'd0;
            tick_d    = '0;
            frame_d   = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            load_k_q  <= 2'd0;
            tick_q    <= '0;
            frame_q   <= 3'd0;
            dec_q     <= BLANK_DIGIT;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            load_k_q  <= load_k_d;
            tick_q    <= tick_d;
            frame_q   <= frame_d;
            dec_q     <= dec_d;
            aborted_q <= aborted_d;
        end
    end

    assign dec       = dec_q;
    assign frame_idx = frame_q;
    assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_scroll_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_scroll_ctrl                                             |
// | Brief   : Directed self-checking bench for scroll_ctrl (TICK_DIV=4)  |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_scroll_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_dec;
    logic       in_valid;
    logic       in_ready;
    logic       abort;
    logic [3:0] dec;
    logic       rd;
    logic       clean;
    logic       frame_tick;
    logic [2:0] frame_idx;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    scroll_ctrl #(
        .TICK_DIV   (4),
        .FIFO_DEPTH (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_dec     (in_dec),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .abort      (abort),
        .dec        (dec),
        .rd         (rd),
        .clean      (clean),
        .frame_tick (frame_tick),
        .frame_idx  (frame_idx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [3:0] d);
        in_dec   = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Starts at the first LOAD cycle, ends at the first SCROLL cycle.
    task automatic check_load(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2);
        chk("load_k0_rd", rd, 1);
        chk("load_k0_busy", busy, 1);
        tick();
        chk("load_k1_rd", rd, 1);
        chk("load_k1_dec", dec, d0);
        tick();
        chk("load_k2_rd", rd, 1);
        chk("load_k2_dec", dec, d1);
        tick();
        chk("load_gap_rd", rd, 0);
        chk("load_gap_dec", dec, d2);
        tick();
    endtask

    // Starts at the first SCROLL cycle, ends at the CLEAR cycle.
    task automatic check_scroll(input logic exp_clean);
        for (int f = 0; f < 7; f++) begin
            for (int t = 0; t < 4; t++) begin
                chk("scroll_frame_idx", frame_idx, 8'(f));
                chk("scroll_frame_tick", frame_tick, (t == 3) ? 8'd1 : 8'd0);
                chk("scroll_clean", clean, 0);
                chk("scroll_done", done, 0);
                tick();
            end
        end
        chk("clear_clean", clean, 8'(exp_clean));
        chk("clear_done", done, 1);
        chk("clear_frame_tick", frame_tick, 0);
        chk("clear_frame_idx", frame_idx, 0);
        chk("clear_busy", busy, 1);
    endtask

    initial begin
        rst      = 1'b1;
        in_dec   = 4'h0;
        in_valid = 1'b0;
        abort    = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        chk("rst_in_ready", in_ready, 1);
        chk("rst_dec", dec, 8'h0F);
        chk("rst_rd", rd, 0);
        chk("rst_clean", clean, 0);
        chk("rst_frame_tick", frame_tick, 0);
        chk("rst_frame_idx", frame_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

`ifdef SCROLL_CTRL_LOOP_EN
        push(4'h1); push(4'h2); push(4'h3);
        tick();
        check_load(4'h1, 4'h2, 4'h3);
        check_scroll(1'b0);
        tick();
        check_scroll(1'b0);
        tick();
        chk("loop_replay_busy", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("loop_abort_clean", clean, 1);
        chk("loop_abort_done", done, 0);
        tick();
        chk("loop_exit_busy", busy, 0);
`else
        // Idle with no input.
        repeat (100) begin
            tick();
            chk("idle_busy", busy, 0);
            chk("idle_rd", rd, 0);
        end
        chk("idle_dec", dec, 8'h0F);
        chk("idle_in_ready", in_ready, 1);

        // Single message.
        push(4'h1); push(4'h2); push(4'h3);
        chk("single_pre_load_rd", rd, 0);
        tick();
        check_load(4'h1, 4'h2, 4'h3);
        check_scroll(1'b1);
        tick();
        chk("single_idle_busy", busy, 0);
        chk("single_idle_clean", clean, 0);
        chk("single_idle_done", done, 0);

        // Two digits wait; the third starts a load.
        push(4'h5); push(4'h6);
        repeat (200) begin
            chk("two_digit_rd", rd, 0);
            tick();
        end
        push(4'h7);
        tick();
        check_load(4'h5, 4'h6, 4'h7);
        check_scroll(1'b1);
        tick();
        chk("two_digit_idle_busy", busy, 0);

        // Back-to-back passes.
        push(4'h1); push(4'h2); push(4'h3);
        fork
            begin
                tick();
                check_load(4'h1, 4'h2, 4'h3);
                check_scroll(1'b1);
            end
            begin
                push(4'h4); push(4'h5); push(4'h6);
            end
        join
        tick();
        check_load(4'h4, 4'h5, 4'h6);
        check_scroll(1'b1);
        tick();
        chk("b2b_idle_busy", busy, 0);

        // Fill the FIFO while a pass runs; the 9th digit waits for a pop.
        push(4'h1); push(4'h2); push(4'h3);
        tick();
        fork
            begin
                check_load(4'h1, 4'h2, 4'h3);
                check_scroll(1'b1);
            end
            begin
                push(4'h8); push(4'h9); push(4'hA); push(4'hB);
                push(4'hC); push(4'hD); push(4'hE); push(4'h0);
                chk("full_in_ready", in_ready, 0);
                in_dec   = 4'h7;
                in_valid = 1'b1;
            end
        join
        chk("full_hold_in_ready", in_ready, 0);
        tick();
        chk("full_load_k0_rd", rd, 1);
        chk("full_load_k0_in_ready", in_ready, 0);
        tick();
        chk("full_load_k1_in_ready", in_ready, 1);
        chk("full_load_k1_dec", dec, 8'h08);
        tick();
        in_valid = 1'b0;
        chk("full_load_k2_dec", dec, 8'h09);
        tick();
        chk("full_load_gap_rd", rd, 0);
        chk("full_load_gap_dec", dec, 8'h0A);
        tick();
        repeat (12) tick();
        chk("abort_pre_frame_idx", frame_idx, 3);

        // Abort mid-scroll at frame 3 with six digits still buffered.
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_clean", clean, 1);
        chk("abort_done", done, 0);
        chk("abort_frame_idx", frame_idx, 0);
        chk("abort_rd", rd, 0);
        chk("abort_in_ready", in_ready, 1);
        tick();
        chk("abort_idle_busy", busy, 0);
        chk("abort_idle_clean", clean, 0);
        repeat (10) begin
            tick();
            chk("abort_flushed_rd", rd, 0);
            chk("abort_flushed_busy", busy, 0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
